adder_tree_loader: RTL and testbench
====================================

ADDER_TREE_LOADER -- requirements
Module: adder_tree_loader

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 18, the width of one sample and of one adder-tree leaf operand.
REQ-002 SHALL have parameter LANES, default 8, the number of leaf operands per frame (power of two, 2..64).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data, input, ADDER_WIDTH bits: incoming sample.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 SHALL have port in_last, input, 1 bit: sample closes the current frame early; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1 bit: loader accepts a sample this cycle.
REQ-009 SHALL have port out_lanes, output, LANES*ADDER_WIDTH bits: frame operands; lane k at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
REQ-010 SHALL have port out_count, output, $clog2(LANES+1) bits: number of populated lanes in the frame (1..LANES).
REQ-011 SHALL have port out_valid, output, 1 bit: frame on out_lanes/out_count valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream adder tree takes the frame.

Function
REQ-013 SHALL accept a sample when in_valid && in_ready, writing it to fill lane fill_cnt and incrementing fill_cnt.
REQ-014 SHALL use two states: FILL (in_ready=1) and HOLD (in_ready=0).
REQ-015 SHALL treat an accepted sample as completing when fill_cnt==LANES-1 or in_last=1.
REQ-016 SHALL, on a completing sample with output slot free (!out_valid || out_ready), load out_lanes next cycle with fill contents plus the new sample, zero all unpopulated lanes, set out_count=fill_cnt+1, assert out_valid, clear fill_cnt, stay in FILL (latency 1 cycle, zero bubbles).
REQ-017 SHALL, on a completing sample with output slot occupied (out_valid && !out_ready), store the sample, hold the pending count, and go to HOLD.
REQ-018 SHALL, in HOLD, transfer the held frame to the output on the cycle out_ready=1, then return to FILL with fill_cnt=0 (in_ready high the following cycle).
REQ-019 SHALL keep out_lanes, out_count and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL deassert out_valid after out_ready handshake unless a new frame is loaded the same cycle.
REQ-021 SHALL ignore in_data and in_last when in_valid=0; SHALL never drop or duplicate an accepted sample.
REQ-022 SHALL drive in_ready from state only (no combinational path from out_ready or in_valid).
REQ-023 SHALL perform no arithmetic; sample bits pass unchanged.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously force state=FILL, fill_cnt=0, out_valid=0, out_count=0, out_lanes=0; in_ready=1 one clock after rst_n deasserts.
REQ-025 SHALL discard any partial or held frame when reset asserts mid-operation.

Structure
REQ-026 SHALL take ADDER_WIDTH/LANES defaults and the FILL/HOLD state enum from a shared adder_tree_pkg package also used by adder_tree_top.
REQ-027 SHALL be a single module with no sub-modules; lane storage as a LANES-entry register array.

Verification
REQ-028 Full frame: 8 back-to-back samples 1..8, out_ready=1 -> one cycle after 8th accept, out_valid=1, lanes 0..7 = 1..8, out_count=8, in_ready never low.
REQ-029 Early close: samples 0x3FFFF, 5, 7 with in_last on 3rd -> out_lanes lanes 0..2 = 0x3FFFF,5,7, lanes 3..7 = 0, out_count=3.
REQ-030 Backpressure: out_ready=0, send 16 samples -> first frame held stable, second frame completes into HOLD, in_ready=0; raise out_ready -> frames 1 then 2 delivered in order, in_ready=1 cycle after second transfer.
REQ-031 Simultaneous: completing sample on same cycle out_ready=1 with out_valid=1 -> old frame consumed, new frame presented next cycle, no HOLD entry.
REQ-032 Reset mid-frame: 5 samples accepted then rst_n=0 for 1 cycle -> out_valid=0 immediately; next 8 samples 9..16 form frame with lane 0 = 9.
REQ-033 Random valid/ready stress, 10k samples with random in_last -> scoreboard sum of lanes equals sum of sent samples per frame, matching adder_tree_top output.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree datapath: default geometry and the
// loader FSM state encoding. Imported by adder_tree_loader and adder_tree_top.
package adder_tree_pkg;

  localparam int unsigned DEF_ADDER_WIDTH = 18;
  localparam int unsigned DEF_LANES       = 8;

  // FILL: collecting samples (in_ready high); HOLD: a completed frame waits
  // for the output slot (in_ready low).
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } loader_state_e;

endpackage : adder_tree_pkg

// File: rtl/adder_tree_loader.sv
// Collects a stream of samples into fixed-width frames of LANES operands for a
// downstream adder tree. A frame closes after LANES samples or on in_last;
// unpopulated lanes are zeroed and out_count reports how many are populated.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/valid/last    sample stream; in_ready is registered from state
//   out_lanes/count/valid frame to the adder tree, held while out_ready low
//   out_ready             adder tree accepts the presented frame
module adder_tree_loader
  import adder_tree_pkg::*;
#(
  parameter int unsigned ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter int unsigned LANES       = DEF_LANES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDER_WIDTH-1:0]         in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [LANES*ADDER_WIDTH-1:0]   out_lanes,
  output logic [$clog2(LANES+1)-1:0]     out_count,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int unsigned FW = $clog2(LANES);
  localparam int unsigned CW = $clog2(LANES+1);

  loader_state_e state_q, state_d;

  logic [ADDER_WIDTH-1:0]       fill_q [LANES];
  logic [FW-1:0]                fill_cnt_q;
  logic [CW-1:0]                hold_cnt_q;

  logic                         accept_c;
  logic                         complete_c;
  logic                         slot_free_c;
  logic                         load_c;
  logic [CW-1:0]                frame_cnt_c;
  logic [LANES*ADDER_WIDTH-1:0] frame_c;

  // Handshake qualifiers; in_ready is a flop so acceptance never depends on
  // out_ready combinationally.
  always_comb begin
    accept_c    = in_valid && in_ready && (state_q == ST_FILL);
    complete_c  = (fill_cnt_q == FW'(LANES-1)) || in_last;
    slot_free_c = !out_valid || out_ready;
    load_c      = (state_q == ST_FILL && accept_c && complete_c && slot_free_c) ||
                  (state_q == ST_HOLD && out_ready);
  end

  // Frame assembly: in FILL the arriving sample is merged into its lane so the
  // frame loads with one cycle of latency; in HOLD the stored frame is used.
  always_comb begin
    frame_c     = '0;
    frame_cnt_c = (state_q == ST_HOLD) ? hold_cnt_q : (CW'(fill_cnt_q) + CW'(1));
    for (int unsigned k = 0; k < LANES; k++) begin
      if (CW'(k) < frame_cnt_c) begin
        if (state_q == ST_FILL && FW'(k) == fill_cnt_q) begin
          frame_c[k*ADDER_WIDTH +: ADDER_WIDTH] = in_data;
        end else begin
          frame_c[k*ADDER_WIDTH +: ADDER_WIDTH] = fill_q[k];
        end
      end
    end
  end

  // Next-state logic. HOLD implies out_valid, so out_ready alone frees the slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (accept_c && complete_c && !slot_free_c) state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      fill_cnt_q <= '0;
      hold_cnt_q <= '0;
      out_lanes  <= '0;
      out_count  <= '0;
      out_valid  <= 1'b0;
    end else begin
      in_ready <= (state_d == ST_FILL);

      if (accept_c) begin
        if (complete_c) begin
          fill_cnt_q <= '0;
          hold_cnt_q <= CW'(fill_cnt_q) + CW'(1);
        end else begin
          fill_cnt_q <= fill_cnt_q + FW'(1);
        end
      end

      if (load_c) begin
        out_lanes <= frame_c;
        out_count <= frame_cnt_c;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Lane storage; stale contents beyond the fill count are masked on load,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept_c) fill_q[fill_cnt_q] <= in_data;
  end

endmodule : adder_tree_loader

// File: tb/tb_adder_tree_loader.sv
module tb_adder_tree_loader;

  localparam int unsigned W  = 18;
  localparam int unsigned L  = 8;
  localparam int unsigned CW = $clog2(L+1);

  typedef struct packed {
    logic [L*W-1:0] lanes;
    logic [CW-1:0]  cnt;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [L*W-1:0] out_lanes;
  logic [CW-1:0]  out_count;
  logic           out_valid;
  logic           out_ready;

  adder_tree_loader #(.ADDER_WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_lanes(out_lanes), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  frame_t       q[$];
  logic [W-1:0] part[$];
  bit           ov_m;
  bit           hold_m;
  bit           post_reset;
  bit           acc_last;

  task automatic check(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    part.delete();
    ov_m       = 1'b0;
    hold_m     = 1'b0;
    post_reset = 1'b1;
  endtask

  // One cycle: inputs applied just after the falling edge, outputs checked,
  // model advanced to what the next rising edge must produce.
  task automatic drive(input logic [W-1:0] d, input bit v, input bit l, input bit r);
    bit     exp_ready;
    bit     ov_next;
    frame_t f;
    in_data   = d;
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    #1;
    exp_ready = !hold_m && !post_reset;
    check("in_ready", (L*W)'(in_ready), (L*W)'(exp_ready));
    check("out_valid", (L*W)'(out_valid), (L*W)'(ov_m));
    if (ov_m) begin
      if (q.size() == 0) begin
        check("scoreboard_underflow", (L*W)'(1), (L*W)'(0));
      end else begin
        check("out_lanes", out_lanes, q[0].lanes);
        check("out_count", (L*W)'(out_count), (L*W)'(q[0].cnt));
      end
    end
    acc_last = v && exp_ready;
    ov_next  = ov_m;
    if (ov_m && r) begin
      if (q.size() > 0) void'(q.pop_front());
      ov_next = 1'b0;
    end
    if (hold_m && r) begin
      ov_next = 1'b1;
      hold_m  = 1'b0;
    end
    if (acc_last) begin
      part.push_back(d);
      if (part.size() == L || l) begin
        f.lanes = '0;
        foreach (part[i]) f.lanes[i*W +: W] = part[i];
        f.cnt = CW'(part.size());
        q.push_back(f);
        if (!ov_m || r) ov_next = 1'b1;
        else            hold_m  = 1'b1;
        part.delete();
      end
    end
    ov_m       = ov_next;
    post_reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int cyc;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", (L*W)'(out_valid), '0);
    check("rst_out_count", (L*W)'(out_count), '0);
    check("rst_out_lanes", out_lanes, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive('0, 0, 0, 1);   // in_ready comes up one clock after release

    // Full frame, back-to-back 1..8, out_ready high
    for (int i = 1; i <= 8; i++) drive(W'(i), 1, 0, 1);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);

    // Early close on in_last, with max-value sample
    drive(W'(18'h3FFFF), 1, 0, 1);
    drive(W'(5), 1, 0, 1);
    drive(W'(7), 1, 1, 1);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);

    // Backpressure: 16 samples with out_ready low; 2nd frame goes to HOLD
    for (int i = 0; i < 16; i++) drive(W'(100 + i), 1, 0, 0);
    drive('0, 0, 0, 0);
    drive('0, 0, 0, 0);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);

    // Simultaneous consume and load: frame waits, completing sample with out_ready
    for (int i = 0; i < 2; i++) drive(W'(200 + i), 1, i == 1, 0);
    drive(W'(300), 1, 0, 0);
    drive(W'(301), 1, 1, 1);
    drive('0, 0, 0, 0);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);

    // Reset mid-frame with a frame presented
    drive(W'(50), 1, 1, 0);
    for (int i = 0; i < 5; i++) drive(W'(60 + i), 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", (L*W)'(out_valid), '0);
    check("midrst_out_count", (L*W)'(out_count), '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive('0, 0, 0, 1);
    for (int i = 9; i <= 16; i++) drive(W'(i), 1, 0, 1);
    drive('0, 0, 0, 1);
    drive('0, 0, 0, 1);

    // Random valid/ready stress; idle cycles carry junk data and in_last
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      drive(W'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) < 6);
      if (acc_last) sent++;
      cyc++;
    end
    check("stress_sent", (L*W)'(sent), (L*W)'(10000));
    drive('0, 1, 1, 1);
    if (acc_last) sent++;
    for (int i = 0; i < 6; i++) drive('0, 0, 0, 1);
    check("drain_queue", (L*W)'(q.size()), '0);
    check("drain_partial", (L*W)'(part.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_adder_tree_loader
